sd_bus_master: RTL and testbench

SD_BUS_MASTER -- requirements
Module: sd_bus_master

---
 rtl/sd_bus_master.sv | 168 ++++++++++++++++
 tb/tb_sd_bus_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_bus_master.sv
// SD bus master: card-clock generator plus the CMD0 / CMD8 bring-up sequence.
// Checks the R7 reply to CMD8 and settles in DONE or ERROR.
module sd_bus_master #(
    parameter int CLK_HALF     = 1,
    parameter int INIT_CLOCKS  = 80,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic       sdio_clk,
    inout  wire        sdio_cmd,
    inout  wire  [3:0] sdio_data
);

    localparam int MAX_A   = (INIT_CLOCKS > RESP_TIMEOUT) ? INIT_CLOCKS : RESP_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > 48) ? MAX_A : 48;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int DW      = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

    localparam logic [47:0] FRAME0 = 48'h40_0000_0000_95;
    localparam logic [47:0] FRAME8 = 48'h48_0000_01AA_87;

    typedef enum logic [3:0] {
        RESET     = 4'd0,
        INIT      = 4'd1,
        SEND0     = 4'd2,
        GAP       = 4'd3,
        SEND8     = 4'd4,
        WAIT_RESP = 4'd5,
        RECV      = 4'd6,
        DONE      = 4'd7,
        ERROR     = 4'd8
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [CW-1:0] bit_cnt;
    logic [47:0]   tx_sr;
    logic [45:0]   rx_sr;
    logic [6:0]    crc;
    logic          cmd_oe;
    logic          cmd_out;

    logic          tick;
    logic          fall;
    logic          rise;
    logic          cmd_in;
    logic [46:0]   rx_word;
    logic [6:0]    crc_next;
    logic          resp_ok;

    assign tick = (state != RESET) && (div_cnt == DW'(CLK_HALF - 1));
    assign fall = tick && sdio_clk;
    assign rise = tick && !sdio_clk;

    assign sdio_cmd  = cmd_oe ? cmd_out : 1'bz;
    assign sdio_data = 4'bzzzz;
    assign cmd_in    = sdio_cmd;

    // rx_word is the reply without its start bit once the last bit arrives
    assign rx_word  = {rx_sr, cmd_in};
    assign crc_next = {crc[5:0], 1'b0} ^ ((cmd_in ^ crc[6]) ? 7'h09 : 7'h00);
    assign resp_ok  = !rx_word[46]
                   && (rx_word[45:40] == 6'd8)
                   && (rx_word[19:8] == 12'h1AA)
                   && (rx_word[7:1] == crc)
                   && rx_word[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            sdio_clk <= 1'b0;
        end else if (state == RESET) begin
            div_cnt  <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            sdio_clk <= ~sdio_clk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RESET;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            crc     <= '0;
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b0;
        end else begin
            unique case (state)
                RESET: state <= INIT;
                INIT: if (fall) begin
                    if (bit_cnt == CW'(INIT_CLOCKS)) begin
                        state   <= SEND0;
                        cmd_out <= FRAME0[47];
                        tx_sr   <= {FRAME0[46:0], 1'b0};
                        bit_cnt <= CW'(1);
                    end else begin
                        cmd_oe  <= 1'b1;
                        cmd_out <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                SEND0: if (fall) begin
                    if (bit_cnt == CW'(48)) begin
                        state   <= GAP;
                        cmd_oe  <= 1'b0;
                        bit_cnt <= CW'(1);
                    end else begin
                        cmd_out <= tx_sr[47];
                        tx_sr   <= {tx_sr[46:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                GAP: if (fall) begin
                    if (bit_cnt == CW'(8)) begin
                        state   <= SEND8;
                        cmd_oe  <= 1'b1;
                        cmd_out <= FRAME8[47];
                        tx_sr   <= {FRAME8[46:0], 1'b0};
                        bit_cnt <= CW'(1);
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                SEND8: if (fall) begin
                    if (bit_cnt == CW'(48)) begin
                        state   <= WAIT_RESP;
                        cmd_oe  <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        cmd_out <= tx_sr[47];
                        tx_sr   <= {tx_sr[46:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                // start bit is 0, so the CRC over it stays at its zero seed
                WAIT_RESP: if (rise) begin
                    if (!cmd_in) begin
                        state   <= RECV;
                        rx_sr   <= '0;
                        crc     <= '0;
                        bit_cnt <= CW'(1);
                    end else if (bit_cnt == CW'(RESP_TIMEOUT - 1)) begin
                        state   <= ERROR;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RECV: if (rise) begin
                    rx_sr   <= rx_word[45:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt < CW'(40))
                        crc <= crc_next;
                    if (bit_cnt == CW'(47))
                        state <= resp_ok ? DONE : ERROR;
                end
                DONE:  cmd_oe <= 1'b0;
                ERROR: cmd_oe <= 1'b0;
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_bus_master.sv
// Bench for sd_bus_master: schedule-based bus model checked every clk,
// plus card replies, literal frame captures and an async reset mid-command.
module tb_sd_bus_master;

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_INIT  = 4'd1;
    localparam logic [3:0] S_SEND0 = 4'd2;
    localparam logic [3:0] S_GAP   = 4'd3;
    localparam logic [3:0] S_SEND8 = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_RECV  = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERROR = 4'd8;

    localparam logic [47:0] CMD0_F = 48'h400000000095;
    localparam logic [47:0] CMD8_F = 48'h48000001AA87;
    localparam int          P      = 186;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sdio_clk;
    wire        sdio_cmd;
    wire  [3:0] sdio_data;
    logic       card_oe = 1'b0;
    logic       card_bit = 1'b1;

    pullup pu_cmd (sdio_cmd);
    pullup pu_d0 (sdio_data[0]);
    pullup pu_d1 (sdio_data[1]);
    pullup pu_d2 (sdio_data[2]);
    pullup pu_d3 (sdio_data[3]);

    assign sdio_cmd = card_oe ? card_bit : 1'bz;

    sd_bus_master dut (
        .clk       (clk),
        .reset     (reset),
        .sdio_clk  (sdio_clk),
        .sdio_cmd  (sdio_cmd),
        .sdio_data (sdio_data)
    );

    always #5 clk = ~clk;

    int          ncyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          mode = 1;
    logic        resp_good = 1'b1;
    logic [47:0] resp_word = 48'h0;
    logic [47:0] cap0 = 48'h0;
    logic [47:0] cap8 = 48'h0;
    int          err_n = -1;
    int          cf;

    always @(posedge clk or posedge reset)
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;

    task automatic check(string name, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s n=%0d actual=%0h required=%0h",
                         name, ncyc, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // index of the most recent sdio_clk fall, -1 before the first one
    function automatic int fall_of(int n);
        return (n >= 3) ? (n - 3) / 2 : -1;
    endfunction

    function automatic logic exp_oe(int f);
        return (f >= 0 && f < 128) || (f >= 136 && f < 184);
    endfunction

    function automatic logic exp_bit(int f);
        if (f < 80)  return 1'b1;
        if (f < 128) return CMD0_F[127 - f];
        return CMD8_F[183 - f];
    endfunction

    function automatic logic card_act(int f);
        return (mode != 0) && f >= P && f <= P + 47;
    endfunction

    function automatic logic card_b(int f);
        return resp_word[47 - (f - P)];
    endfunction

    function automatic logic [3:0] exp_state(int n);
        int f;
        f = fall_of(n);
        if (n == 0)  return S_RESET;
        if (f < 80)  return S_INIT;
        if (f < 128) return S_SEND0;
        if (f < 136) return S_GAP;
        if (f < 184) return S_SEND8;
        if (mode == 0) return (n >= 372 + 2 * 63) ? S_ERROR : S_WAIT;
        if (n < 4 + 2 * P) return S_WAIT;
        if (n < 4 + 2 * (P + 47)) return S_RECV;
        return resp_good ? S_DONE : S_ERROR;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        cf = fall_of(ncyc);
        card_oe  = card_act(cf);
        card_bit = card_act(cf) ? card_b(cf) : 1'b1;
    end

    always @(negedge clk) begin
        int         n;
        int         f;
        logic       ew;
        logic [3:0] st;
        n  = ncyc;
        f  = fall_of(n);
        st = dut.state;
        ew = exp_oe(f) ? exp_bit(f) : (card_act(f) ? card_b(f) : 1'b1);
        check("sdio_clk", 48'(sdio_clk), 48'(n >= 2 && n % 2 == 0));
        check("cmd_oe", 48'(dut.cmd_oe), 48'(exp_oe(f)));
        check("sdio_cmd", 48'(sdio_cmd), 48'(ew));
        check("sdio_data", 48'(sdio_data), 48'hF);
        check("state", 48'(st), 48'(exp_state(n)));
        if (n >= 4 && n % 2 == 0) begin
            if (f >= 80 && f <= 127)  cap0 = {cap0[46:0], sdio_cmd};
            if (f >= 136 && f <= 183) cap8 = {cap8[46:0], sdio_cmd};
        end
        if (err_n < 0 && st == S_ERROR) err_n = n;
    end

    task automatic start(int m, logic [47:0] w, logic good);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        mode = m;
        resp_word = w;
        resp_good = good;
        cap0 = 48'h0;
        cap8 = 48'h0;
        err_n = -1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic finish_run(string name, logic [3:0] fin);
        check({name, "_cmd0"}, cap0, CMD0_F);
        check({name, "_cmd8"}, cap8, CMD8_F);
        check({name, "_final"}, 48'(dut.state), 48'(fin));
    endtask

    logic [47:0] good_r7;
    logic [47:0] echo_r7;

    initial begin
        good_r7 = {40'h08000001AA, crc7(40'h08000001AA), 1'b1};
        echo_r7 = {40'h08000000AA, crc7(40'h08000000AA), 1'b1};
        check("r7_literal", good_r7, 48'h08000001AA13);
        check("cmd0_crc", 48'(crc7(40'h4000000000)), 48'h4A);
        check("cmd8_crc", 48'(crc7(40'h48000001AA)), 48'h43);

        start(1, good_r7, 1'b1);
        repeat (480) @(negedge clk);
        finish_run("good", S_DONE);
        check("good_no_err", 48'(err_n), 48'hFFFF_FFFF_FFFF);

        start(0, 48'h0, 1'b0);
        repeat (510) @(negedge clk);
        finish_run("noreply", S_ERROR);
        check("timeout_cycle", 48'(err_n), 48'd498);

        start(1, good_r7 ^ 48'h2, 1'b0);
        repeat (480) @(negedge clk);
        finish_run("badcrc", S_ERROR);

        start(1, echo_r7, 1'b0);
        repeat (480) @(negedge clk);
        finish_run("echo0aa", S_ERROR);

        start(1, good_r7, 1'b1);
        repeat (300) @(negedge clk);
        check("pre_rst_oe", 48'(dut.cmd_oe), 48'h1);
        #2 reset = 1'b1;
        #1;
        check("async_clk", 48'(sdio_clk), 48'h0);
        check("async_oe", 48'(dut.cmd_oe), 48'h0);
        check("async_state", 48'(dut.state), 48'(S_RESET));
        cap0 = 48'h0;
        cap8 = 48'h0;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (480) @(negedge clk);
        finish_run("rerun", S_DONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
